alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake on both sides and a serial shifter.
// Define ALU_EXEC_BARREL_SHIFT_EN to make shifts single-cycle through a barrel shifter instead.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
  localparam logic [1:0] S_BUSY = 2'd1;
`endif

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic [1:0]  r_state;
  logic [31:0] r_result;
  logic        r_illegal;

  logic [31:0] w_alu;
  logic        w_illegal;
  logic [4:0]  w_shamt;
  logic        w_go_busy;

  assign w_shamt = src2[4:0];

  always_comb begin
    w_alu     = src1 + src2;
    w_illegal = 1'b0;
    case (alu_ctrl)
      OP_ADD:  w_alu = src1 + src2;
      OP_SUB:  w_alu = src1 - src2;
      OP_SLT:  w_alu = {31'd0, ($signed(src1) < $signed(src2))};
      OP_SLTU: w_alu = {31'd0, (src1 < src2)};
      OP_XOR:  w_alu = src1 ^ src2;
      OP_OR:   w_alu = src1 | src2;
      OP_AND:  w_alu = src1 & src2;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      OP_SLL:  w_alu = src1 << w_shamt;
      OP_SRL:  w_alu = src1 >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(src1) >>> w_shamt);
`else
      // Only zero-amount shifts complete here; nonzero amounts go through BUSY.
      OP_SLL, OP_SRL, OP_SRA: w_alu = src1;
`endif
      default: begin
        w_alu     = src1 + src2;
        w_illegal = 1'b1;
      end
    endcase
  end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
  logic [31:0] r_shv;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  logic        r_sign;
  logic [31:0] w_step;
  logic        w_last;

  assign w_go_busy = ((alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA))
                     && (w_shamt != 5'd0);
  assign w_last    = (r_cnt == 5'd1);

  always_comb begin
    w_step = {r_sign, r_shv[31:1]};
    case (r_op)
      OP_SLL:  w_step = {r_shv[30:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_shv[31:1]};
      default: w_step = {r_sign, r_shv[31:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shv  <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_sign <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) && in_valid && w_go_busy) begin
      r_shv  <= src1;
      r_cnt  <= w_shamt;
      r_op   <= alu_ctrl;
      r_sign <= src1[31];
    end else if (r_state == S_BUSY) begin
      r_shv <= w_step;
      r_cnt <= r_cnt - 5'd1;
    end
  end
`else
  assign w_go_busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_illegal <= w_illegal;
            if (w_go_busy) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
              r_state <= S_BUSY;
`endif
            end else begin
              r_state  <= S_DONE;
              r_result <= w_alu;
            end
          end
        end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
        S_BUSY: begin
          if (w_last) begin
            r_state  <= S_DONE;
            r_result <= w_step;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign illegal   = r_illegal;

endmodule
